// File: rtl/collatz_sync_resp.sv
// collatz_sync_resp
//   Responder for the sync valid/ready handshake. Accepts one start value,
//   iterates the Collatz map until it reaches 1 (or 0), and returns the
//   number of steps taken. Overflow of 3x+1 beyond N bits or reaching
//   MAX_STEPS terminates early with out_err set and the partial count.
//
//   Optional build macro: COLLATZ_SKIP_EN
//     When defined, an odd step also performs the following halving in the
//     same cycle (cnt += 2). Results are identical; only latency shrinks.
//
// Ports
//   clk        in   system clock, rising edge
//   nrst       in   asynchronous active-low reset
//   in_valid   in   request strobe
//   in_ready   out  idle, able to accept
//   in0        in   start value (N bits), sampled on accept
//   out_valid  out  result available, held until consumed
//   out_ready  in   initiator consumes result
//   out0       out  step count (partial count on error)
//   out_err    out  overflow or step limit reached
module collatz_sync_resp #(
    parameter int N         = 27,
    parameter int MAX_STEPS = 1023
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in0,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out0,
    output logic         out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] x_q, x_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out0_q, out0_d;
    logic         out_err_q, out_err_d;

    // 3x+1 at N+2 bits so overflow past N bits is visible in the top bits
    logic [N+1:0] t;
    // Step counter widened so the MAX_STEPS compare works for any N
    logic [63:0]  cnt_w;
    logic         at_max;

    always_comb begin
        t      = ({2'b00, x_q} << 1) + {2'b00, x_q} + (N+2)'(1);
        cnt_w  = 64'(cnt_q);
        at_max = (cnt_w == 64'(MAX_STEPS));

        state_d     = state_q;
        x_d         = x_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out0_d      = out0_q;
        out_err_d   = out_err_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d        = in0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (x_q <= N'(1)) begin
                    out0_d      = cnt_q;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (at_max) begin
                    out0_d      = cnt_q;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (!x_q[0]) begin
                    x_d   = x_q >> 1;
                    cnt_d = cnt_q + N'(1);
                end else if (t[N+1:N] != 2'b00) begin
                    out0_d      = cnt_q;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
`ifdef COLLATZ_SKIP_EN
                    // t is even, so its halving step is folded in here unless
                    // the double step would run past the step limit.
                    if (cnt_w + 64'd2 <= 64'(MAX_STEPS)) begin
                        x_d   = t[N:1];
                        cnt_d = cnt_q + N'(2);
                    end else begin
                        x_d   = t[N-1:0];
                        cnt_d = cnt_q + N'(1);
                    end
`else
                    x_d   = t[N-1:0];
                    cnt_d = cnt_q + N'(1);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out0_q      <= out0_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out0      = out0_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_collatz_sync_resp.sv
// Bench for collatz_sync_resp: three instances (default, N=8, MAX_STEPS=10)
// driven by directed and random requests, checked against a plain-arithmetic
// Collatz reference.
module tb_collatz_sync_resp;

    logic        clk;
    logic        nrst;
    logic [26:0] in0;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  out_err;
    logic [26:0] out0_0;
    logic [7:0]  out0_1;
    logic [26:0] out0_2;

    int n_assert;
    int n_fail;

    collatz_sync_resp #(.N(27), .MAX_STEPS(1023)) u0 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in0(in0), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out0(out0_0), .out_err(out_err[0])
    );

    collatz_sync_resp #(.N(8), .MAX_STEPS(1023)) u1 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in0(in0[7:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out0(out0_1), .out_err(out_err[1])
    );

    collatz_sync_resp #(.N(27), .MAX_STEPS(10)) u2 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in0(in0), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out0(out0_2), .out_err(out_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned get_out0(input int sel);
        case (sel)
            0:       return longint'(out0_0);
            1:       return longint'(out0_1);
            default: return longint'(out0_2);
        endcase
    endfunction

    function automatic int width_of(input int sel);
        return (sel == 1) ? 8 : 27;
    endfunction

    function automatic int max_of(input int sel);
        return (sel == 2) ? 10 : 1023;
    endfunction

    // Collatz reference: counts map applications until the value is <= 1,
    // stopping with an error when the limit is reached or 3x+1 no longer
    // fits in n bits.
    function automatic void model(input longint unsigned v, input int n, input int mx,
                                  output int steps, output bit err);
        longint unsigned x;
        x     = v;
        steps = 0;
        err   = 1'b0;
        forever begin
            if (x <= 1) return;
            if (steps == mx) begin err = 1'b1; return; end
            if (x % 2 == 0) begin
                x = x / 2;
            end else begin
                if (3 * x + 1 >= (64'd1 << n)) begin err = 1'b1; return; end
                x = 3 * x + 1;
            end
            steps++;
        end
    endfunction

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_le(input string tag, input longint unsigned obs, input longint unsigned lim);
        n_assert++;
        assert (obs <= lim) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected<=%0d", tag, obs, lim);
        end
    endtask

    // One full transaction on instance sel; out_ready[sel] must be 1.
    task automatic run(input int sel, input logic [26:0] v, input string tag);
        int  exp_steps;
        bit  exp_err;
        int  lat;
        model(longint'(v) & ((64'd1 << width_of(sel)) - 1), width_of(sel), max_of(sel),
              exp_steps, exp_err);
        chk({tag, "_ready"}, in_ready[sel], 1);
        in_valid[sel] = 1'b1;
        in0           = v;
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
        lat = 0;
        while (!out_valid[sel] && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_done"}, out_valid[sel], 1);
`ifdef COLLATZ_SKIP_EN
        chk_le({tag, "_lat"}, lat, exp_steps + 1);
`else
        chk({tag, "_lat"}, lat, exp_steps + 1);
`endif
        chk({tag, "_out0"}, get_out0(sel), exp_steps);
        chk({tag, "_err"}, out_err[sel], exp_err);
        @(posedge clk);
        #1;
        chk({tag, "_consumed"}, {out_valid[sel], in_ready[sel]}, 2'b01);
    endtask

    initial begin
        int  lat;
        bit  spurious;
        n_assert  = 0;
        n_fail    = 0;
        nrst      = 1'b0;
        in0       = '0;
        in_valid  = '0;
        out_ready = '1;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        chk("rst_in_ready", in_ready, 3'b111);
        chk("rst_out_valid", out_valid, 3'b000);
        chk("rst_out0", out0_0, 0);
        chk("rst_out_err", out_err, 3'b000);

        // Directed values on the default instance
        run(0, 27'd1, "v1");
        run(0, 27'd6, "v6");
        run(0, 27'd27, "v27");
        run(0, 27'd0, "v0");
        // Overflow at N=8, step limit at MAX_STEPS=10
        run(1, 27'd27, "n8_27");
        run(2, 27'd27, "max10_27");
        run(2, 27'd6, "max10_6");

        // Backpressure: result held, new requests ignored
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in0          = 27'd6;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_done", out_valid[0], 1);
        for (int i = 0; i < 20; i++) begin
            in_valid[0] = i[0];
            in0         = 27'd3;
            @(posedge clk);
            #1;
            chk("bp_hold", {out_valid[0], in_ready[0], out_err[0], 27'(out0_0)},
                {1'b1, 1'b0, 1'b0, 27'd8});
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_consume", {out_valid[0], in_ready[0]}, 2'b01);
        spurious = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid[0] || !in_ready[0]) spurious = 1'b1;
        end
        chk("bp_no_queue", spurious, 0);

        // Reset in the middle of a long computation
        in_valid[0] = 1'b1;
        in0         = 27'd27;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_running", {out_valid[0], in_ready[0]}, 2'b00);
        nrst = 1'b0;
        #1;
        chk("mid_rst_vals", {out_valid[0], in_ready[0], out_err[0], 27'(out0_0)},
            {1'b0, 1'b1, 1'b0, 27'd0});
        @(posedge clk);
        #1;
        nrst = 1'b1;
        spurious = 1'b0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (out_valid[0]) spurious = 1'b1;
        end
        chk("mid_no_result", spurious, 0);
        run(0, 27'd6, "post_rst6");

        // Random requests against the reference
        for (int i = 0; i < 16; i++) run(0, 27'($urandom_range(0, 200000)), "rnd_small");
        for (int i = 0; i < 6; i++)  run(0, 27'($urandom), "rnd_wide");
        for (int i = 0; i < 12; i++) run(1, 27'($urandom_range(0, 255)), "rnd_n8");
        for (int i = 0; i < 8; i++)  run(2, 27'($urandom_range(0, 1000)), "rnd_max10");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
